// File: rtl/mips_pipe_pkg.sv
// Shared fetch-stage types and constants: FSM state encoding, NOP encoding, PC increment.
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    REDIRECT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam int          PC_STEP   = 4;

endpackage

// File: rtl/stall_watchdog.sv
// Counts consecutive hold cycles, saturating at MAX_STALL, and pulses timeout once
// when the count first reaches MAX_STALL; re-arms only after the hold is released.
module stall_watchdog #(
  parameter int MAX_STALL = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic stall,
  output logic timeout
);

  localparam int CNT_W = $clog2(MAX_STALL + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STALL);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    cnt_d     = '0;
    timeout_d = 1'b0;
    if (stall) begin
      cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      timeout_d = (cnt_q == CNT_MAX - 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;

endmodule

// File: rtl/fetch_stage_ctrl.sv
// Fetch stage: PC register, IF/ID register, stall/flush/bubble handling and stall watchdog.
// Optional FETCH_PERF_CNT_EN adds saturating hold and flush performance counters.
module fetch_stage_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int              DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int              MAX_STALL = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_en,
  input  logic              ifid_hold,
  input  logic              ctrl_bubble,
  input  logic              flush_n,
  input  logic              pc_src,
  input  logic              jump,
  input  logic [DATA_W-1:0] branch_target,
  input  logic [DATA_W-1:0] jump_target,
  input  logic [DATA_W-1:0] imem_instr,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [DATA_W-1:0] ifid_pc4,
  output logic              ifid_valid,
  output logic              idex_ctrl_zero,
  output logic              stall_timeout,
  output logic [1:0]        fsm_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  localparam logic [DATA_W-1:0] NOP  = DATA_W'(NOP_INSTR);
  localparam logic [DATA_W-1:0] STEP = DATA_W'(PC_STEP);

  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [DATA_W-1:0] ifid_pc4_q, ifid_pc4_d;
  logic              ifid_valid_q, ifid_valid_d;
  logic              idex_ctrl_zero_q, idex_ctrl_zero_d;
  fetch_state_e      state_q, state_d;

  logic [DATA_W-1:0] pc_plus4;
  logic              redirect;
  logic              ifid_flush;

  assign pc_plus4   = pc_q + STEP;
  assign redirect   = pc_en & (jump | pc_src);
  assign ifid_flush = ~ifid_hold & (~flush_n | redirect);

  always_comb begin
    pc_d = pc_q;
    if (pc_en) begin
      if (jump)        pc_d = {jump_target[DATA_W-1:2], 2'b00};
      else if (pc_src) pc_d = {branch_target[DATA_W-1:2], 2'b00};
      else             pc_d = pc_plus4;
    end
  end

  // A flushed slot keeps its old pc4; only the instruction and valid bit are squashed.
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    if (!ifid_hold) begin
      if (ifid_flush) begin
        ifid_instr_d = NOP;
        ifid_valid_d = 1'b0;
      end else begin
        ifid_instr_d = imem_instr;
        ifid_pc4_d   = pc_plus4;
        ifid_valid_d = 1'b1;
      end
    end
  end

  assign idex_ctrl_zero_d = ctrl_bubble | ~ifid_valid_q;

  always_comb begin
    state_d = RUN;
    if (ifid_hold)                        state_d = STALL;
    else if (state_q == RUN && redirect)  state_d = REDIRECT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q             <= RESET_PC;
      ifid_instr_q     <= NOP;
      ifid_pc4_q       <= '0;
      ifid_valid_q     <= 1'b0;
      idex_ctrl_zero_q <= 1'b0;
      state_q          <= RUN;
    end else begin
      pc_q             <= pc_d;
      ifid_instr_q     <= ifid_instr_d;
      ifid_pc4_q       <= ifid_pc4_d;
      ifid_valid_q     <= ifid_valid_d;
      idex_ctrl_zero_q <= idex_ctrl_zero_d;
      state_q          <= state_d;
    end
  end

  // The watchdog counts the same condition that drives the FSM into STALL.
  stall_watchdog #(
    .MAX_STALL(MAX_STALL)
  ) u_stall_watchdog (
    .clk     (clk),
    .reset   (reset),
    .stall   (ifid_hold),
    .timeout (stall_timeout)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (ifid_hold  && perf_stall_q != '1) perf_stall_d = perf_stall_q + 32'd1;
    if (ifid_flush && perf_flush_q != '1) perf_flush_d = perf_flush_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

  assign pc             = pc_q;
  assign ifid_instr     = ifid_instr_q;
  assign ifid_pc4       = ifid_pc4_q;
  assign ifid_valid     = ifid_valid_q;
  assign idex_ctrl_zero = idex_ctrl_zero_q;
  assign fsm_state      = state_q;

endmodule
